// File: rtl/gb_joypad_input.sv
// gb_joypad_input: polls an SNES serial pad and presents it as the Game Boy JOYP register
module gb_joypad_input #(
  parameter int POLL_DIV     = 450000,
  parameter int LATCH_CYCLES = 324,
  parameter int HALF_BIT     = 162
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        controller_data,
  output logic        controller_latch,
  output logic        controller_clock,
  input  logic        mem_enable,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [15:0] A,
  input  logic [7:0]  di,
  output logic [7:0]  dout,
  input  logic        int_ack,
  output logic        int_req,
  output logic [7:0]  button_state
);
  localparam int CW = $clog2(LATCH_CYCLES > HALF_BIT ? LATCH_CYCLES : HALF_BIT);
  localparam int PW = $clog2(POLL_DIV);
  localparam logic [CW-1:0] LAT_LAST  = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HB_LAST   = CW'(HALF_BIT - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);

  typedef enum logic [2:0] {IDLE, LATCH, HIGH, LOW, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   raw_q, raw_d;
  logic [1:0]    sync_q, sync_d;
  logic [7:0]    btn_q, btn_d;
  logic [1:0]    sel_q, sel_d;
  logic          wr_n_q, wr_n_d;
  logic [3:0]    nib_q, nib_d;
  logic          int_q, int_d;
  logic          hit, cnt_last;
  logic [3:0]    nib;
  logic          unused_rd_n;

  assign unused_rd_n  = rd_n;
  assign hit          = mem_enable && A == 16'hFF00;
  assign nib          = (sel_q[0] ? 4'h0 : btn_q[3:0]) | (sel_q[1] ? 4'h0 : btn_q[7:4]);
  assign dout         = hit ? {2'b11, sel_q, ~nib} : 8'hFF;
  assign cnt_last     = cnt_q == (state_q == LATCH ? LAT_LAST : HB_LAST);
  assign button_state = btn_q;
  assign int_req      = int_q;

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: latch, then 16 high/low shift periods, then one commit cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = poll_q == '0 ? LATCH : IDLE;
      LATCH:   state_d = cnt_last ? HIGH : LATCH;
      HIGH:    state_d = cnt_last ? LOW : HIGH;
      LOW:     state_d = cnt_last ? (bit_q == 4'd15 ? DONE : HIGH) : LOW;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs to the controller header
  always_comb begin
    controller_latch = state_q == LATCH;
    controller_clock = state_q != LOW;
  end

  // Datapath next values: poll timer, shift capture, frame commit, JOYP select and interrupt
  always_comb begin
    sync_d = {sync_q[0], controller_data};
    poll_d = poll_q == POLL_LAST ? '0 : poll_q + PW'(1);
    cnt_d  = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CW'(1);
    bit_d  = state_q == LATCH ? 4'd0 : (state_q == LOW && cnt_last) ? bit_q + 4'd1 : bit_q;
    raw_d  = raw_q;
    if (state_q == HIGH && cnt_last) raw_d[bit_q] = sync_q[1];
    btn_d  = (state_q == DONE && &raw_q[15:12])
           ? {~raw_q[3], ~raw_q[2], ~raw_q[0], ~raw_q[8], ~raw_q[5], ~raw_q[4], ~raw_q[6], ~raw_q[7]}
           : btn_q;
    wr_n_d = wr_n;
    sel_d  = (hit && !wr_n && wr_n_q) ? di[5:4] : sel_q;
    nib_d  = nib;
    int_d  = |(nib & ~nib_q) ? 1'b1 : int_ack ? 1'b0 : int_q;
  end

  // Datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      poll_q <= '0;
      cnt_q  <= '0;
      bit_q  <= '0;
      raw_q  <= '0;
      btn_q  <= '0;
      wr_n_q <= 1'b1;
      sel_q  <= 2'b11;
      nib_q  <= '0;
      int_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      poll_q <= poll_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      raw_q  <= raw_d;
      btn_q  <= btn_d;
      wr_n_q <= wr_n_d;
      sel_q  <= sel_d;
      nib_q  <= nib_d;
      int_q  <= int_d;
    end
  end
endmodule

// File: tb/tb_gb_joypad_input.sv
// tb_gb_joypad_input: directed and random checks of the joypad poller against a behavioural model
module tb_gb_joypad_input;
  logic        clock = 1'b0, reset = 1'b1;
  logic        controller_data, controller_latch, controller_clock;
  logic        mem_enable = 1'b1, rd_n = 1'b1, wr_n = 1'b1, int_ack = 1'b0, int_req;
  logic [15:0] A = 16'hFF00;
  logic [7:0]  di = 8'h00, dout, button_state;
  logic [15:0] ctrl_raw = 16'hFFFF;
  int          idx = 0;
  int          tests = 0, failed = 0;
  logic [1:0]  m_sel = 2'b11;
  logic [7:0]  m_bs = 8'h00;
  logic        m_int = 1'b0;

  gb_joypad_input #(.POLL_DIV(200), .LATCH_CYCLES(8), .HALF_BIT(4)) dut (
    .clock(clock), .reset(reset), .controller_data(controller_data),
    .controller_latch(controller_latch), .controller_clock(controller_clock),
    .mem_enable(mem_enable), .rd_n(rd_n), .wr_n(wr_n), .A(A), .di(di), .dout(dout),
    .int_ack(int_ack), .int_req(int_req), .button_state(button_state)
  );

  always #5 clock = ~clock;

  // SNES pad: latch presents bit 0, each rising shift clock advances to the next bit, pull-up after 16
  always @(posedge controller_clock or posedge controller_latch) idx <= controller_latch ? 0 : idx + 1;
  assign controller_data = controller_latch ? ctrl_raw[0] : (idx < 16 ? ctrl_raw[idx[3:0]] : 1'b1);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] map_buttons(input logic [15:0] raw);
    int t[8] = '{7, 6, 4, 5, 8, 0, 2, 3};
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = ~raw[t[i]];
    return b;
  endfunction

  function automatic logic [3:0] nib_of(input logic [1:0] s, input logic [7:0] b);
    logic [3:0] n = 4'h0;
    if (!s[0]) n = n | b[3:0];
    if (!s[1]) n = n | b[7:4];
    return n;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic note(input logic [1:0] s, input logic [7:0] b);
    if (|(nib_of(s, b) & ~nib_of(m_sel, m_bs))) m_int = 1'b1;
    m_sel = s;
    m_bs  = b;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_btn"}, button_state, m_bs);
    chk({tag, "_do"}, dout, {2'b11, m_sel, ~nib_of(m_sel, m_bs)});
    chk({tag, "_int"}, int_req, m_int);
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge clock);
    di = d;
    wr_n = 1'b0;
    @(negedge clock);
    wr_n = 1'b1;
    note(d[5:4], m_bs);
    @(negedge clock);
  endtask

  task automatic ack();
    @(negedge clock);
    int_ack = 1'b1;
    @(negedge clock);
    int_ack = 1'b0;
    m_int = 1'b0;
  endtask

  task automatic wait_latch();
    int n = 0;
    while (controller_latch !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("latch_seen", controller_latch, 1'b1);
  endtask

  task automatic frame(input logic [15:0] raw);
    ctrl_raw = raw;
    wait_latch();
    repeat (145) @(negedge clock);
    if (raw[15:12] == 4'hF) note(m_sel, map_buttons(raw));
  endtask

  initial begin
    int n, w, falls, lows, bad, run;
    logic prev;
    logic [15:0] r;
    repeat (3) @(negedge clock);
    chk("rst_latch", controller_latch, 1'b0);
    chk("rst_cclk", controller_clock, 1'b1);
    chk("rst_do", dout, 8'hFF);
    chk("rst_btn", button_state, 8'h00);
    chk("rst_int", int_req, 1'b0);
    reset = 1'b0;
    n = 0;
    while (controller_latch !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("latch_start", (n >= 1 && n <= 2), 1'b1);
    w = 0;
    while (controller_latch === 1'b1 && w < 50) begin
      @(negedge clock);
      w++;
    end
    chk("latch_width", w, 8);
    falls = 0; lows = 0; bad = 0; run = 0; prev = controller_clock;
    repeat (140) begin
      @(negedge clock);
      if (!controller_clock) begin
        lows++;
        run++;
        if (prev) falls++;
      end else begin
        if (!prev && run != 4) bad++;
        run = 0;
      end
      prev = controller_clock;
    end
    chk("clk_pulses", falls, 16);
    chk("clk_low_cycles", lows, 64);
    chk("clk_pulse_len_bad", bad, 0);
    check_all("disc0");
    wr(8'h10);
    frame(16'hFEFF);
    chk("a_do", dout, 8'hDE);
    check_all("a_press");
    ack();
    check_all("a_ack");
    frame(16'hFEFF);
    check_all("a_repeat");
    frame(16'hFFEF);
    check_all("b_up");
    wr(8'h20);
    chk("b_do20", dout, 8'hEB);
    check_all("b_sel20");
    ack();
    wr(8'h30);
    chk("b_do30", dout, 8'hFF);
    check_all("b_sel30");
    wr(8'h20);
    chk("b_reexpose_int", int_req, 1'b1);
    check_all("b_reexpose");
    ack();
    A = 16'hFF01;
    #1 chk("nohit_addr_do", dout, 8'hFF);
    A = 16'hFF00;
    mem_enable = 1'b0;
    #1 chk("nohit_en_do", dout, 8'hFF);
    mem_enable = 1'b1;
    frame(16'hFEFF);
    check_all("c_good");
    frame(16'h0EFF);
    chk("c_btn_hold", button_state, 8'h10);
    check_all("c_bad_sig");
    ack();
    frame(16'hFFFF);
    chk("d_disc_btn", button_state, 8'h00);
    check_all("d_disc");
    wr(8'h30);
    frame(16'hFF7F);
    check_all("d_right");
    ack();
    @(negedge clock);
    di = 8'h20;
    wr_n = 1'b0;
    @(negedge clock);
    wr_n = 1'b1;
    int_ack = 1'b1;
    @(negedge clock);
    int_ack = 1'b0;
    note(2'b10, m_bs);
    chk("d_set_wins", int_req, 1'b1);
    check_all("d_set_ack");
    ack();
    for (int i = 0; i < 6; i++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 1) == 1) r[15:12] = 4'hF;
      wr(8'($urandom));
      frame(r);
      check_all("rand");
      ack();
      check_all("rand_ack");
    end
    frame(16'hFEFF);
    check_all("e_pre");
    ack();
    ctrl_raw = 16'hFF7F;
    wait_latch();
    falls = 0; n = 0; prev = controller_clock;
    while (falls < 7 && n < 300) begin
      @(negedge clock);
      n++;
      if (prev && !controller_clock) falls++;
      prev = controller_clock;
    end
    chk("e_in_low", controller_clock, 1'b0);
    reset = 1'b1;
    #1;
    chk("e_cclk", controller_clock, 1'b1);
    chk("e_latch", controller_latch, 1'b0);
    chk("e_btn", button_state, 8'h00);
    chk("e_int", int_req, 1'b0);
    chk("e_do", dout, 8'hFF);
    m_sel = 2'b11; m_bs = 8'h00; m_int = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (100) @(negedge clock);
    chk("e_btn_hold", button_state, 8'h00);
    repeat (50) @(negedge clock);
    note(m_sel, map_buttons(16'hFF7F));
    check_all("e_commit");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/gb_joypad_input.md
Name: gb_joypad_input

Overview:
- Polls an SNES-style serial controller and maps its buttons onto the Game Boy P1/JOYP register at 0xFF00.
- Sits between the controller header pins and the MMU: it provides the JOYP read data to the MMU read mux and raises the joypad interrupt request (int_req[4]) toward the interrupt module.
- Runs on the 27 MHz board clock, decoupled from the CPU clock.

Parameters:
- POLL_DIV, 450000: clock cycles between successive latch pulses (60 Hz at 27 MHz); must exceed LATCH_CYCLES + 32*HALF_BIT.
- LATCH_CYCLES, 324: width of the latch pulse in cycles (12 us).
- HALF_BIT, 162: cycles per controller_clock half-period (6 us); minimum 4.

Ports:
- clock  input  1  27 MHz system clock.
- reset  input  1  asynchronous, active-high reset.
- controller_data  input  1  serial data from controller; active-low buttons, asynchronous to clock.
- controller_latch  output  1  latch pulse to controller.
- controller_clock  output  1  shift clock to controller; idles high.
- mem_enable  input  1  MMU decode strobe for this block.
- rd_n  input  1  CPU read strobe, active low.
- wr_n  input  1  CPU write strobe, active low.
- A  input  16  CPU address.
- di  input  8  CPU write data.
- do  output  8  read data to MMU.
- int_ack  input  1  joypad interrupt acknowledge, one-cycle-or-longer pulse.
- int_req  output  1  joypad interrupt request, level.
- button_state  output  8  debounced pressed state, active high: {Start, Select, B, A, Down, Up, Left, Right}.

Behaviour:
- Reset is asynchronous, active high. Reset values:
  - controller_latch=0, controller_clock=1, int_req=0, button_state=0.
  - Select bits sel[1:0]=2'b11, so do=8'hFF.
  - FSM=IDLE; poll counter, bit counter and shift register all 0.
- controller_data passes through a 2-flop synchronizer. All samples use the synchronized value.
- The poll counter runs free 0..POLL_DIV-1. When it wraps to 0 while in IDLE, the FSM enters LATCH.
- FSM states: IDLE -> LATCH -> HIGH -> LOW -> (HIGH | DONE) -> IDLE.
  - LATCH: controller_latch=1 for LATCH_CYCLES cycles; controller_clock=1. Bit index k=0.
  - HIGH: controller_clock=1 for HALF_BIT cycles. On the last cycle, raw[k] is sampled from the synchronized data.
  - LOW: controller_clock=0 for HALF_BIT cycles. Then k increments. If k was 15, go to DONE; otherwise return to HIGH.
  - DONE: one cycle, then IDLE.
- The rising edge of controller_clock on LOW->HIGH shifts the controller's next bit.
- SNES raw bit order: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R, 12-15 unused (read high).
- Frame commit in DONE:
  - The frame is accepted only if raw[15:12]==4'b1111. Otherwise it is discarded and button_state holds its value.
  - On accept, button_state <= {~raw3, ~raw2, ~raw0, ~raw8, ~raw5, ~raw4, ~raw6, ~raw7}, updated atomically.
  - A disconnected controller with the data pull-up reads all 1s, which commits all-released.
- Register 0xFF00:
  - Hit = mem_enable && A==16'hFF00.
  - Write: committed on the first cycle with hit, wr_n=0, and the registered previous wr_n=1. Then sel <= di[5:4]; other bits are ignored.
  - Read data is combinational: do = hit ? {2'b11, sel, ~nib} : 8'hFF.
  - nib = (sel[0]==0 ? button_state[3:0] : 0) | (sel[1]==0 ? button_state[7:4] : 0).
  - Both select bits low ORs the two nibbles. Both select bits high gives low nibble 4'hF.
  - rd_n does not gate do.
- Interrupt:
  - Each cycle, cur = nib is compared against the previous cycle's nib.
  - Any bit going 0->1 (a new press visible under the current select) sets int_req.
  - int_ack clears int_req.
  - If set and ack occur in the same cycle, set wins.
  - A select change that newly exposes an already-held button also counts as a 0->1 transition (Game Boy behaviour).
- Reset mid-frame: outputs return to their reset values immediately, the partial frame is lost, and the poll counter restarts at 0.
- Writes to 0xFF00 during a frame are independent of the FSM. Register access never stalls.

Test Plan:
- Parameters for all scenarios: POLL_DIV=200, HALF_BIT=4, LATCH_CYCLES=8.
- Reset -> latch=0, clock=1, do=FF with A=FF00 and mem_enable=1, button_state=00, int_req=0. After release, first latch rises at cycle 0 of the poll, lasts 8 cycles, followed by exactly 16 clock low pulses of 4 cycles each.
- Controller model drives raw=16'hFEFF (A pressed only). Write di=8'h10 (select buttons) -> after DONE, button_state=8'h10, do=8'hDE, int_req=1. Pulse int_ack -> int_req=0. Next identical frame -> int_req stays 0.
- raw=16'hFFEF (Up). Write 8'h20 (select directions) -> do=8'hEB. Write 8'h30 -> do=8'hFF, no interrupt. Write 8'h20 again -> int_req=1 (newly exposed press).
- raw=16'h0EFF (signature bits 12-15 bad) after a prior accepted frame of 16'hFEFF -> button_state stays 8'h10.
- Controller disconnected (data held 1) -> button_state=00. Assert int_ack in the same cycle as a new press edge -> int_req=1.
- Assert reset during the 7th bit's LOW phase -> controller_clock=1 and latch=0 in the same cycle. button_state keeps its reset value 00 until the next full frame commits.
